// File: rtl/adder_share_ctrl_if.sv
// Bundle of requester-side and adder-side signals around the shared-adder sequencer.
// master = clients plus adder instance, slave = adder_share_ctrl.
interface adder_share_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin0;
    logic             cin1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] result;
    logic             result_c_out;
    logic             err;
    logic             busy;
    logic             grant;
    logic             adder_en;
    logic [WIDTH-1:0] adder_A;
    logic [WIDTH-1:0] adder_B;
    logic             adder_c_in;
    logic             adder_ready;
    logic [WIDTH-1:0] adder_Output;
    logic             adder_c_out;

    modport master (
        output req0, req1, a0, b0, a1, b1, cin0, cin1,
        output adder_ready, adder_Output, adder_c_out,
        input  ack0, ack1, result, result_c_out, err, busy, grant,
        input  adder_en, adder_A, adder_B, adder_c_in
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, cin0, cin1,
        input  adder_ready, adder_Output, adder_c_out,
        output ack0, ack1, result, result_c_out, err, busy, grant,
        output adder_en, adder_A, adder_B, adder_c_in
    );
endinterface

// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer sharing one adder between two requesters.
// Optional WAIT watchdog enabled by defining ADDER_TIMEOUT_EN.
module adder_share_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 32
) (
    input logic           clk,
    input logic           reset,
    adder_share_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             grant_q, grant_d;
    logic             lastGrant_q, lastGrant_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             opCin_q, opCin_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             resultC_q, resultC_d;
    logic             err_q, err_d;
    logic             winner;
    logic             timeoutHit;

`ifdef ADDER_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] waitCnt_q;

    // Counts cycles spent in WAIT; zero on the first WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt_q <= '0;
        end else if (state_q == WAIT) begin
            waitCnt_q <= waitCnt_q + CntW'(1);
        end else begin
            waitCnt_q <= '0;
        end
    end

    assign timeoutHit = (waitCnt_q == CntW'(TIMEOUT - 1));
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT;
    assign timeoutHit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        opCin_d     = opCin_q;
        result_d    = result_q;
        resultC_d   = resultC_q;
        err_d       = err_q;
        winner      = 1'b0;
        case (state_q)
            IDLE: begin
                // A ready left high from a previous transaction must not start a new one.
                if ((bus.req0 || bus.req1) && !bus.adder_ready) begin
                    winner      = (bus.req0 && bus.req1) ? ~lastGrant_q : bus.req1;
                    grant_d     = winner;
                    lastGrant_d = winner;
                    opA_d       = winner ? bus.a1 : bus.a0;
                    opB_d       = winner ? bus.b1 : bus.b0;
                    opCin_d     = winner ? bus.cin1 : bus.cin0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.adder_ready) begin
                    result_d  = bus.adder_Output;
                    resultC_d = bus.adder_c_out;
                    state_d   = DONE;
                end else if (timeoutHit) begin
                    err_d     = 1'b1;
                    result_d  = '0;
                    resultC_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            opA_q       <= '0;
            opB_q       <= '0;
            opCin_q     <= 1'b0;
            result_q    <= '0;
            resultC_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            opCin_q     <= opCin_d;
            result_q    <= result_d;
            resultC_q   <= resultC_d;
            err_q       <= err_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.adder_en     = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.ack0         = (state_q == DONE) && !grant_q;
    assign bus.ack1         = (state_q == DONE) && grant_q;
    assign bus.grant        = grant_q;
    assign bus.adder_A      = opA_q;
    assign bus.adder_B      = opB_q;
    assign bus.adder_c_in   = opCin_q;
    assign bus.result       = result_q;
    assign bus.result_c_out = resultC_q;
    assign bus.err          = err_q;
endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Sequencer/arbiter sharing one 16-bit ripple/CLA adder (en/ready handshake, A/B/c_in in, Output/c_out out) between two requesters.
- Round-robin grant; latches winner's operands, drives adder en, waits for adder ready, returns result with one-cycle ack to winner.
- Sits between ALU-side clients and the single adder instance.

Parameters:
- WIDTH, 16, operand/result width; must match adder.
- TIMEOUT, 32, max WAIT cycles before abort (used only with ADDER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  request level; held until matching ack.
- a0, b0, a1, b1  in  WIDTH each  requester operands; stable while req high.
- cin0, cin1  in  1 each  requester carry-in.
- ack0, ack1  out  1 each  one-cycle completion pulse to requester.
- result  out  WIDTH  sum; valid in ack cycle, held until next ack.
- result_c_out  out  1  carry-out; same validity as result.
- err  out  1  timeout flag (ADDER_TIMEOUT_EN only, else tied 0).
- busy  out  1  high in any state except IDLE.
- grant  out  1  index of current/last served requester.
- adder_en  out  1  adder enable.
- adder_A, adder_B  out  WIDTH  latched operands.
- adder_c_in  out  1  latched carry-in.
- adder_ready  in  1  adder result valid.
- adder_Output  in  WIDTH  adder sum.
- adder_c_out  in  1  adder carry-out.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; last_grant=1 so req0 wins first tie.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Arbitrate only when (req0|req1) && !adder_ready; a stale adder_ready blocks issue.
  - Winner = sole requester, or on tie the one != last_grant.
  - Latch operands into adder_A/B/c_in; set grant and last_grant; -> ISSUE.
- ISSUE: adder_en=1; adder_ready ignored this cycle; -> WAIT.
- WAIT:
  - adder_en held 1.
  - On first cycle adder_ready=1: register adder_Output/adder_c_out into result/result_c_out; -> DONE.
- DONE:
  - adder_en=0; ack[grant]=1 for exactly one cycle.
  - -> IDLE. Requester must drop or change req the cycle after ack; a req still high is a new request.
- Latency: req sampled in IDLE cycle N; ISSUE N+1; WAIT from N+2; if ready first seen at cycle M (M>=N+2), ack at M+1. Minimum 3 cycles req-to-ack.
- Throughput: at most one operation in flight; adder_A/B/c_in constant ISSUE through DONE.
- Req deasserted after grant: operation still completes and ack still pulses; no cancel.
- Operand changes after grant are ignored.
- busy=1 in ISSUE/WAIT/DONE.
- err sticky, cleared only by reset.
- Reset mid-operation: immediate return to IDLE, adder_en=0, no ack, result cleared to 0.

Optional Feature:
- Macro ADDER_TIMEOUT_EN.
- Defined:
  - WAIT counter starts at 0 on entry and counts cycles in WAIT.
  - If it reaches TIMEOUT with adder_ready still 0: set err=1, result=0, result_c_out=0, -> DONE (ack still pulses so requester unblocks).
  - adder_ready=1 in the same cycle as expiry counts as success.
- Undefined: no counter; WAIT lasts indefinitely; err tied 0.

Test Plan:
- req0, a0=127, b0=127, cin0=0, adder completes normally -> adder_en high from ISSUE; ack0 one cycle; result=254; result_c_out=0; ack1 never.
- a1=0xFFFF, b1=0x0001, cin1=0, req1 only -> ack1; result=0x0000; result_c_out=1; grant=1.
- req0 and req1 asserted together, both held until acked -> first ack0 (result a0+b0), then ack1 (result a1+b1); never two acks in one cycle.
- Both reqs held continuously for 4 ops -> grants alternate 0,1,0,1.
- reset pulsed while in WAIT -> all outputs 0 asynchronously; no ack; next req0 with 1+1 -> result=2.
- ADDER_TIMEOUT_EN, TIMEOUT=32, adder_ready stuck 0 -> ack pulses exactly 32 WAIT cycles after WAIT entry; err=1; result=0; without the macro, busy stays 1 and no ack.
